// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter
// ---------------------------------------------------------------------------
// Two-port arbiter in front of a single-ported synchronous memory. Port 0
// belongs to the debug shell, port 1 to the CPU. Only one transaction is in
// flight at a time, and each transaction takes three cycles:
//   T   : IDLE  - winner is accepted (valid && ready), payload latched
//   T+1 : ISSUE - mem_cs asserted with the latched address/data
//   T+2 : RESP  - memory returns read data, which is captured
//   T+3 : IDLE  - rsp_valid pulses on the owning port; the next accept may
//                 happen in this same cycle
//
// Ports
//   CLK, r_reset          clock (rising edge) and synchronous active-high reset
//   i_cpu_mode            0 = shell mode (only port 0 eligible), 1 = CPU mode
//   reqN_valid/write/addr/wdata   request from port N
//   reqN_ready            combinational grant; accept = valid && ready
//   rspN_valid            one-cycle completion pulse for port N
//   rspN_rdata            last read data for port N (held between reads)
//   mem_cs/we/addr/wdata  memory strobe and payload (registered)
//   mem_rdata             memory read data, valid the cycle after mem_cs
//   o_busy                high while a transaction is in flight
//   o_txn_count           completed-transaction counter, wraps at 16 bits
// ---------------------------------------------------------------------------
module rom_bus_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          r_reset,
    input  logic          i_cpu_mode,

    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,

    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,

    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,

    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          o_busy,
    output logic [15:0]   o_txn_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;

    // last_grant_r holds the port number granted most recently; 1 after
    // reset so that port 0 wins the first tie.
    logic          last_grant_r;
    logic          lat_port_r;
    logic          lat_write_r;

    logic          mem_cs_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;

    logic          rsp0_valid_r;
    logic          rsp1_valid_r;
    logic [DW-1:0] rsp0_rdata_r;
    logic [DW-1:0] rsp1_rdata_r;
    logic [15:0]   txn_count_r;
    logic          busy_r;

    logic          elig0_s;
    logic          elig1_s;
    logic          grant0_s;
    logic          grant1_s;
    logic          accept_s;
    logic          sel_write_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic          complete_s;
    logic          complete0_s;
    logic          complete1_s;

    // Arbitration: eligibility by mode, round-robin on a tie, grants only in IDLE.
    always_comb begin
        elig0_s  = req0_valid;
        elig1_s  = req1_valid & i_cpu_mode;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == ST_IDLE) && !r_reset) begin
            if (elig0_s && elig1_s) begin
                // Tie: the port that was not granted last time wins.
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (elig0_s) begin
                grant0_s = 1'b1;
            end else if (elig1_s) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    // A grant is only ever given to a valid requester, so a grant is an accept.
    assign accept_s   = grant0_s | grant1_s;

    // Payload of the accepted request.
    always_comb begin
        sel_write_s = req0_write;
        sel_addr_s  = req0_addr;
        sel_wdata_s = req0_wdata;
        if (grant1_s) begin
            sel_write_s = req1_write;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
        end else begin
            sel_write_s = req0_write;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
        end
    end

    // Next-state logic of the transaction sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_RESP;
            ST_RESP:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    assign complete_s  = (state_r == ST_RESP);
    assign complete0_s = complete_s & ~lat_port_r;
    assign complete1_s = complete_s &  lat_port_r;

    // State register and busy flag.
    always_ff @(posedge CLK) begin
        if (r_reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Grant history and latched transaction attributes, updated on accept only.
    always_ff @(posedge CLK) begin
        if (r_reset) begin
            last_grant_r <= 1'b1;
            lat_port_r   <= 1'b0;
            lat_write_r  <= 1'b0;
        end else if (accept_s) begin
            last_grant_r <= grant1_s;
            lat_port_r   <= grant1_s;
            lat_write_r  <= sel_write_s;
        end
    end

    // Memory strobes: set by the accept edge so they are high exactly in ISSUE.
    always_ff @(posedge CLK) begin
        if (r_reset) begin
            mem_cs_r <= 1'b0;
            mem_we_r <= 1'b0;
        end else begin
            mem_cs_r <= accept_s;
            mem_we_r <= accept_s & sel_write_s;
        end
    end

    // Memory address/data: loaded on accept, held otherwise.
    always_ff @(posedge CLK) begin
        if (r_reset) begin
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
        end else if (accept_s) begin
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
        end
    end

    // Completion pulses, visible the cycle after RESP.
    always_ff @(posedge CLK) begin
        if (r_reset) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else begin
            rsp0_valid_r <= complete0_s;
            rsp1_valid_r <= complete1_s;
        end
    end

    // Read data capture; mem_rdata is valid during RESP, writes leave it alone.
    always_ff @(posedge CLK) begin
        if (r_reset) begin
            rsp0_rdata_r <= {DW{1'b0}};
            rsp1_rdata_r <= {DW{1'b0}};
        end else begin
            if (complete0_s && !lat_write_r) begin
                rsp0_rdata_r <= mem_rdata;
            end
            if (complete1_s && !lat_write_r) begin
                rsp1_rdata_r <= mem_rdata;
            end
        end
    end

    // Completed-transaction counter; natural 16-bit wrap.
    always_ff @(posedge CLK) begin
        if (r_reset) begin
            txn_count_r <= 16'd0;
        end else if (complete_s) begin
            txn_count_r <= txn_count_r + 16'd1;
        end
    end

    assign mem_cs      = mem_cs_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign rsp0_valid  = rsp0_valid_r;
    assign rsp1_valid  = rsp1_valid_r;
    assign rsp0_rdata  = rsp0_rdata_r;
    assign rsp1_rdata  = rsp1_rdata_r;
    assign o_busy      = busy_r;
    assign o_txn_count = txn_count_r;

endmodule
